// File: rtl/physics_pkg.sv
// Shared types, constants and helpers for the physics divide arbiter slice.
// The round-robin grant search and magnitude helper live here so every block agrees on them.
package physics_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_WIDTH   = 32;
   localparam int DEF_ID_W    = 2;

   localparam logic [DEF_WIDTH-1:0] SAT_POS = 32'h7FFF_FFFF;
   localparam logic [DEF_WIDTH-1:0] SAT_NEG = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // First asserted request after ptr, wrapping; returns ptr when nothing is requesting.
   function automatic logic [DEF_ID_W-1:0] rr_next(input logic [DEF_NUM_REQ-1:0] req,
                                                   input logic [DEF_ID_W-1:0]    ptr);
      logic                found;
      logic [DEF_ID_W-1:0] idx;
      rr_next = ptr;
      found   = 1'b0;
      for (int k = 1; k <= DEF_NUM_REQ; k++) begin
         idx = DEF_ID_W'((int'(ptr) + k) % DEF_NUM_REQ);
         if (!found && req[idx]) begin
            rr_next = idx;
            found   = 1'b1;
         end
      end
   endfunction

   // Unsigned magnitude; the most negative value maps onto itself read as unsigned.
   function automatic logic [DEF_WIDTH-1:0] magnitude(input logic [DEF_WIDTH-1:0] v);
      if (v[DEF_WIDTH-1]) begin
         magnitude = (~v) + {{(DEF_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         magnitude = v;
      end
   endfunction

endpackage

// File: rtl/physics_div_arbiter_if.sv
// Request/response bundle between the per-player physics units and the shared divider.
interface physics_div_arbiter_if
   import physics_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_dividend;
   logic [NUM_REQ*WIDTH-1:0] req_divisor;
   logic [NUM_REQ-1:0]       req_ready;
   logic [NUM_REQ-1:0]       resp_valid;
   logic [WIDTH-1:0]         resp_quotient;
   logic                     resp_div_zero;
   logic                     resp_sat;
   logic                     busy;

   modport master (
      output req_valid, req_dividend, req_divisor,
      input  req_ready, resp_valid, resp_quotient, resp_div_zero, resp_sat, busy
   );

   modport slave (
      input  req_valid, req_dividend, req_divisor,
      output req_ready, resp_valid, resp_quotient, resp_div_zero, resp_sat, busy
   );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, WIDTH cycles per divide.
module seq_divider
   import physics_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient
);
   localparam int              CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic             running_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH:0]   rem_sh_s;
   logic [WIDTH-1:0] diff_s;
   logic             fits_s;

   // Shift the next dividend bit into the partial remainder and trial-subtract.
   always_comb begin
      rem_sh_s = {rem_r, quo_r[WIDTH-1]};
      fits_s   = (rem_sh_s >= {1'b0, dvs_r});
      diff_s   = rem_sh_s[WIDTH-1:0] - dvs_r;
   end

   // Iteration state: the quotient register doubles as the dividend shifter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         running_r <= 1'b0;
         cnt_r     <= '0;
         rem_r     <= '0;
         quo_r     <= '0;
         dvs_r     <= '0;
      end else if (start) begin
         running_r <= 1'b1;
         cnt_r     <= '0;
         rem_r     <= '0;
         quo_r     <= dividend;
         dvs_r     <= divisor;
      end else if (running_r) begin
         rem_r <= fits_s ? diff_s : rem_sh_s[WIDTH-1:0];
         quo_r <= {quo_r[WIDTH-2:0], fits_s};
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         if (cnt_r == LAST) begin
            running_r <= 1'b0;
         end
      end
   end

   assign done     = running_r && (cnt_r == LAST);
   assign quotient = quo_r;
endmodule

// File: rtl/physics_div_arbiter.sv
// Round-robin front end sharing one sequential divider among the player physics units;
// handles operand signs, zero-divisor and overflow saturation, and result routing.
module physics_div_arbiter
   import physics_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ID_W    = DEF_ID_W
) (
   input  logic                  clock,
   input  logic                  reset,
   physics_div_arbiter_if.slave  bus
);
   state_t            state_r, state_s;
   logic [ID_W-1:0]   rr_ptr_r, tag_r, grant_s;
   logic [WIDTH-1:0]  dividend_r, divisor_r;
   logic [WIDTH-1:0]  sel_dividend_s, sel_divisor_s;
   logic [NUM_REQ-1:0] ready_s, resp_valid_s;
   logic [WIDTH-1:0]  quotient_s, div_quo_s;
   logic              div_zero_s, sat_s, accept_s, start_s, div_done_s, busy_r;

   assign grant_s        = rr_next(bus.req_valid, rr_ptr_r);
   assign sel_dividend_s = bus.req_dividend[grant_s*WIDTH +: WIDTH];
   assign sel_divisor_s  = bus.req_divisor[grant_s*WIDTH +: WIDTH];
   assign accept_s       = |ready_s;
   assign start_s        = accept_s && (sel_divisor_s != '0);

   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clock    (clock),
      .reset    (reset),
      .start    (start_s),
      .dividend (magnitude(sel_dividend_s)),
      .divisor  (magnitude(sel_divisor_s)),
      .done     (div_done_s),
      .quotient (div_quo_s)
   );

   // Next state and the single-cycle grant; ready is held low while reset is applied.
   always_comb begin
      state_s = state_r;
      ready_s = '0;
      case (state_r)
         IDLE: begin
            if (!reset && (|bus.req_valid)) begin
               ready_s[grant_s] = 1'b1;
               state_s = (sel_divisor_s == '0) ? DONE : DIVIDE;
            end else begin
               state_s = IDLE;
            end
         end
         DIVIDE: begin
            if (div_done_s) begin
               state_s = DONE;
            end else begin
               state_s = DIVIDE;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, pointer and latched operands; the pointer moves only on an accepted request.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         rr_ptr_r   <= ID_W'(NUM_REQ - 1);
         tag_r      <= '0;
         dividend_r <= '0;
         divisor_r  <= '0;
         busy_r     <= 1'b0;
      end else begin
         state_r <= state_s;
         busy_r  <= (state_s != IDLE);
         if (accept_s) begin
            rr_ptr_r   <= grant_s;
            tag_r      <= grant_s;
            dividend_r <= sel_dividend_s;
            divisor_r  <= sel_divisor_s;
         end
      end
   end

   // Signed result assembly; everything is decoded from registers and gated by DONE.
   always_comb begin
      resp_valid_s = '0;
      quotient_s   = '0;
      div_zero_s   = 1'b0;
      sat_s        = 1'b0;
      if (state_r == DONE) begin
         resp_valid_s[tag_r] = 1'b1;
         if (divisor_r == '0) begin
            quotient_s = dividend_r[WIDTH-1] ? SAT_NEG : SAT_POS;
            div_zero_s = 1'b1;
            sat_s      = 1'b1;
         end else if ((dividend_r == SAT_NEG) && (divisor_r == '1)) begin
            quotient_s = SAT_POS;
            sat_s      = 1'b1;
         end else if (dividend_r[WIDTH-1] ^ divisor_r[WIDTH-1]) begin
            quotient_s = (~div_quo_s) + {{(WIDTH-1){1'b0}}, 1'b1};
         end else begin
            quotient_s = div_quo_s;
         end
      end else begin
         resp_valid_s = '0;
      end
   end

   assign bus.req_ready     = ready_s;
   assign bus.resp_valid    = resp_valid_s;
   assign bus.resp_quotient = quotient_s;
   assign bus.resp_div_zero = div_zero_s;
   assign bus.resp_sat      = sat_s;
   assign bus.busy          = busy_r;
endmodule

// File: tb/tb_physics_div_arbiter.sv
// Directed bench for physics_div_arbiter: a vector table of single divides plus
// hand-written round-robin, withdrawal and mid-divide reset sequences.
module tb_physics_div_arbiter;
   import physics_pkg::*;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   physics_div_arbiter_if bus ();

   physics_div_arbiter dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          idx;
      logic [31:0] dd;
      logic [31:0] ds;
      logic [31:0] q;
      logic        dz;
      logic        sat;
      int          lat;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] oh(input int i);
      logic [3:0] r;
      r    = 4'b0000;
      r[i] = 1'b1;
      return r;
   endfunction

   task automatic set_req(input int idx, input logic v, input logic [31:0] dd, input logic [31:0] ds);
      bus.req_valid[idx]             = v;
      bus.req_dividend[idx*32 +: 32] = dd;
      bus.req_divisor[idx*32 +: 32]  = ds;
   endtask

   // One request from an idle arbiter; optionally another requester pulses valid mid-divide.
   task automatic do_vec(input vec_t v, input int intr);
      @(negedge clock);
      set_req(v.idx, 1'b1, v.dd, v.ds);
      #1;
      chk("accept_ready", {28'd0, bus.req_ready}, {28'd0, oh(v.idx)});
      chk("accept_busy", {31'd0, bus.busy}, 32'd0);
      for (int k = 1; k <= v.lat; k++) begin
         @(negedge clock);
         if (k == 1) set_req(v.idx, 1'b0, ~v.dd, 32'd3);
         if (intr >= 0 && k == 5) set_req(intr, 1'b1, 32'd9, 32'd3);
         if (intr >= 0 && k == 10) set_req(intr, 1'b0, 32'd9, 32'd3);
         #1;
         if (k == 1) chk("run_busy", {31'd0, bus.busy}, 32'd1);
         if (k == 1 || (intr >= 0 && k == 7)) chk("run_ready", {28'd0, bus.req_ready}, 32'd0);
         if (k == v.lat - 1) chk("early_resp", {28'd0, bus.resp_valid}, 32'd0);
         if (k == v.lat) begin
            chk("resp_valid", {28'd0, bus.resp_valid}, {28'd0, oh(v.idx)});
            chk("resp_quotient", bus.resp_quotient, v.q);
            chk("resp_div_zero", {31'd0, bus.resp_div_zero}, {31'd0, v.dz});
            chk("resp_sat", {31'd0, bus.resp_sat}, {31'd0, v.sat});
         end
      end
      @(negedge clock);
      #1;
      chk("post_busy", {31'd0, bus.busy}, 32'd0);
      chk("post_resp", {28'd0, bus.resp_valid}, 32'd0);
      chk("post_flags", {30'd0, bus.resp_sat, bus.resp_div_zero}, 32'd0);
   endtask

   initial begin
      int cnt;
      int seen;
      logic [3:0] exp_order [5];
      total = 0;
      bad   = 0;
      bus.req_valid    = '0;
      bus.req_dividend = '0;
      bus.req_divisor  = '0;
      reset = 1'b1;

      vecs[0]  = '{0, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0, 33};
      vecs[1]  = '{1, -32'sd100,      32'd7,          32'hFFFF_FFF2,  1'b0, 1'b0, 33};
      vecs[2]  = '{2, 32'd100,        -32'sd7,        32'hFFFF_FFF2,  1'b0, 1'b0, 33};
      vecs[3]  = '{3, -32'sd100,      -32'sd7,        32'd14,         1'b0, 1'b0, 33};
      vecs[4]  = '{0, 32'h0005_0000,  32'd2,          32'h0002_8000,  1'b0, 1'b0, 33};
      vecs[5]  = '{2, 32'd5,          32'd0,          32'h7FFF_FFFF,  1'b1, 1'b1, 1};
      vecs[6]  = '{1, -32'sd5,        32'd0,          32'h8000_0000,  1'b1, 1'b1, 1};
      vecs[7]  = '{3, 32'h8000_0000,  32'hFFFF_FFFF,  32'h7FFF_FFFF,  1'b0, 1'b1, 33};
      vecs[8]  = '{0, 32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 1'b0, 33};
      vecs[9]  = '{1, 32'd0,          32'd5,          32'd0,          1'b0, 1'b0, 33};
      vecs[10] = '{2, 32'd7,          32'd100,        32'd0,          1'b0, 1'b0, 33};
      vecs[11] = '{3, -32'sd7,        32'd2,          32'hFFFF_FFFD,  1'b0, 1'b0, 33};

      repeat (2) @(negedge clock);
      #1;
      chk("reset_resp", {28'd0, bus.resp_valid}, 32'd0);
      chk("reset_ready", {28'd0, bus.req_ready}, 32'd0);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_quot", bus.resp_quotient, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) do_vec(vecs[i], -1);

      // Round robin: all four valid continuously from reset.
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 32'd1000 + 32'(i), 32'd1);
      #1;
      chk("rr_reset_ready", {28'd0, bus.req_ready}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      exp_order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      for (int g = 0; g < 5; g++) begin
         cnt = 0;
         while (bus.req_ready == 4'b0000 && cnt < 40) begin
            @(negedge clock);
            #1;
            cnt++;
         end
         chk("rr_onehot", $countones(bus.req_ready), 32'd1);
         chk("rr_grant", {28'd0, bus.req_ready}, {28'd0, oh(int'(exp_order[g]))});
         @(negedge clock);
         #1;
         cnt = 0;
         while (bus.resp_valid == 4'b0000 && cnt < 40) begin
            @(negedge clock);
            #1;
            cnt++;
         end
         chk("rr_resp_route", {28'd0, bus.resp_valid}, {28'd0, oh(int'(exp_order[g]))});
         chk("rr_quot", bus.resp_quotient, 32'd1000 + 32'(exp_order[g]));
         chk("rr_done_ready", {28'd0, bus.req_ready}, 32'd0);
      end
      bus.req_valid = '0;
      repeat (2) @(negedge clock);

      // Withdrawal: req1 pulses valid during a divide and is never served.
      do_vec(vecs[0], 1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         #1;
         chk("withdraw_ready", {28'd0, bus.req_ready}, 32'd0);
         chk("withdraw_resp", {28'd0, bus.resp_valid}, 32'd0);
      end

      // Reset ten cycles into a divide, then requester 0 regains priority.
      @(negedge clock);
      set_req(0, 1'b1, 32'd100, 32'd7);
      #1;
      chk("mid_accept", {28'd0, bus.req_ready}, 32'd1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clock);
         if (k == 1) begin
            set_req(0, 1'b0, 32'd0, 32'd0);
            set_req(3, 1'b1, 32'd3, 32'd1);
         end
      end
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("mid_rst_resp", {28'd0, bus.resp_valid}, 32'd0);
      chk("mid_rst_ready", {28'd0, bus.req_ready}, 32'd0);
      @(negedge clock);
      #1;
      chk("mid_rst_busy2", {31'd0, bus.busy}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      set_req(0, 1'b1, 32'd100, 32'd7);
      #1;
      chk("mid_prio", {28'd0, bus.req_ready}, 32'd1);
      seen = 0;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clock);
         if (k == 1) set_req(0, 1'b0, 32'd0, 32'd0);
         #1;
         if (k < 33 && bus.resp_valid != 4'b0000) seen++;
         if (k == 33) begin
            chk("mid_resp", {28'd0, bus.resp_valid}, 32'd1);
            chk("mid_quot", bus.resp_quotient, 32'd14);
         end
      end
      chk("mid_no_stray", 32'(seen), 32'd0);
      @(negedge clock);
      #1;
      chk("mid_next_grant", {28'd0, bus.req_ready}, 32'd8);
      @(negedge clock);
      set_req(3, 1'b0, 32'd0, 32'd0);
      repeat (36) @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
